// File: rtl/proc_ctrl.sv
// proc_ctrl: multicycle sequencer for the HW3 datapath.
// Walks each instruction through fetch, decode, operand reads, execute and
// writeback, owns the shared memory port through a req/ack handshake and
// evaluates branch conditions against the PSR.
module proc_ctrl #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [4:0]  psr,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_sel,
  output logic        ir_load,
  output logic        src_latch,
  output logic        dst_latch,
  output logic        alu_en,
  output logic        psr_load,
  output logic        reg_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        halted,
  output logic        mem_err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_RD_SRC = 3'd2,
    S_RD_DST = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_BRA = 4'd3;
  localparam logic [3:0] OP_HLT = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_SRC = 2'd1;
  localparam logic [1:0] SEL_DST = 2'd2;

  // Wait counter is wide enough to hold WAIT_LIMIT-1.
  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t          state_reg, state_next;
  logic            mem_err_reg, mem_err_next;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;

  // Raw (ungated) outputs of the FSM; reset forces them low at the ports.
  logic       req_int, we_int;
  logic [1:0] sel_int;
  logic       ir_load_int, src_latch_int, dst_latch_int, alu_en_int;
  logic       psr_load_int, reg_we_int, pc_inc_int, pc_load_int, halted_int;
  logic       timeout;

  // Instruction fields. The IR is stable from ir_load until the next fetch,
  // so later states decode straight from instr rather than a private copy.
  logic [3:0] opcode;
  logic [3:0] cc;
  logic       src_imm;
  logic       is_ld, is_str, is_bra, is_hlt, is_alu;
  logic       cond_true;
  logic       unused_bits;

  assign opcode  = instr[31:28];
  assign cc      = instr[27:24];
  assign src_imm = instr[27];
  assign is_ld   = (opcode == OP_LD);
  assign is_str  = (opcode == OP_STR);
  assign is_bra  = (opcode == OP_BRA);
  assign is_hlt  = (opcode == OP_HLT);
  assign is_alu  = ((opcode >= 4'd4) && (opcode <= 4'd7)) || (opcode == OP_CMP);

  // Address fields are consumed by the datapath, not by this controller.
  assign unused_bits = ^instr[23:0];

  // Branch condition evaluation against PSR {zero, neg, even, parity, carry}.
  always_comb begin
    cond_true = 1'b0;
    case (cc)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = psr[1];
      4'd2:    cond_true = psr[2];
      4'd3:    cond_true = psr[0];
      4'd4:    cond_true = psr[3];
      4'd5:    cond_true = psr[4];
      4'd6:    cond_true = ~psr[0];
      4'd7:    cond_true = ~psr[3] & ~psr[4];
      default: cond_true = 1'b0;
    endcase
  end

  // State, sticky error and ack-wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      mem_err_reg  <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mem_err_reg  <= mem_err_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state, handshake and strobe generation, plus ack timeout override.
  always_comb begin
    state_next    = state_reg;
    mem_err_next  = mem_err_reg;
    wait_cnt_next = '0;
    req_int       = 1'b0;
    we_int        = 1'b0;
    sel_int       = SEL_PC;
    ir_load_int   = 1'b0;
    src_latch_int = 1'b0;
    dst_latch_int = 1'b0;
    alu_en_int    = 1'b0;
    psr_load_int  = 1'b0;
    reg_we_int    = 1'b0;
    pc_inc_int    = 1'b0;
    pc_load_int   = 1'b0;
    halted_int    = 1'b0;
    timeout       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        req_int = 1'b1;
        sel_int = SEL_PC;
        if (mem_ack) begin
          ir_load_int = 1'b1;
          state_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_hlt) begin
          state_next = S_HALT;
        end else if (is_bra) begin
          pc_load_int = cond_true;
          pc_inc_int  = ~cond_true;
          state_next  = S_FETCH;
        end else if (is_ld) begin
          state_next = src_imm ? S_WB : S_RD_SRC;
        end else if (is_str) begin
          state_next = S_WB;
        end else if (is_alu) begin
          state_next = src_imm ? S_RD_DST : S_RD_SRC;
        end else begin
          // NOP and undefined opcodes just advance the PC.
          pc_inc_int = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_RD_SRC: begin
        req_int = 1'b1;
        sel_int = SEL_SRC;
        if (mem_ack) begin
          src_latch_int = 1'b1;
          state_next    = is_ld ? S_WB : S_RD_DST;
        end
      end
      S_RD_DST: begin
        req_int = 1'b1;
        sel_int = SEL_DST;
        if (mem_ack) begin
          dst_latch_int = 1'b1;
          state_next    = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en_int   = 1'b1;
        psr_load_int = 1'b1;
        state_next   = S_WB;
      end
      S_WB: begin
        if (is_ld) begin
          // Register-file write needs no memory access.
          reg_we_int = 1'b1;
          pc_inc_int = 1'b1;
          state_next = S_FETCH;
        end else begin
          req_int = 1'b1;
          we_int  = 1'b1;
          sel_int = SEL_DST;
          if (mem_ack) begin
            pc_inc_int = 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_HALT: begin
        halted_int = 1'b1;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // Count consecutive unacknowledged request cycles; any ack or idle cycle
    // restarts the count so each new request gets a full budget.
    if (WAIT_LIMIT != 0 && req_int && !mem_ack) begin
      if (wait_cnt_reg == CW'(WAIT_LIMIT - 1)) begin
        timeout = 1'b1;
      end else begin
        wait_cnt_next = wait_cnt_reg + CW'(1);
      end
    end

    if (timeout) begin
      mem_err_next  = 1'b1;
      state_next    = S_HALT;
      wait_cnt_next = '0;
    end
  end

  // Reset forces every request and strobe low without waiting for a clock.
  assign mem_req   = req_int       & ~rst;
  assign mem_we    = we_int        & ~rst;
  assign mem_sel   = rst ? SEL_PC : sel_int;
  assign ir_load   = ir_load_int   & ~rst;
  assign src_latch = src_latch_int & ~rst;
  assign dst_latch = dst_latch_int & ~rst;
  assign alu_en    = alu_en_int    & ~rst;
  assign psr_load  = psr_load_int  & ~rst;
  assign reg_we    = reg_we_int    & ~rst;
  assign pc_inc    = pc_inc_int    & ~rst;
  assign pc_load   = pc_load_int   & ~rst;
  assign halted    = halted_int    & ~rst;
  assign mem_err   = mem_err_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: directed + randomized bench for proc_ctrl (WAIT_LIMIT=4).
// Expected per-cycle outputs come from a flat per-opcode phase list: each
// memory phase expands into its wait cycles plus the ack cycle.
module tb_proc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [4:0]  psr = 5'h0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we;
  logic [1:0]  mem_sel;
  logic        ir_load, src_latch, dst_latch, alu_en, psr_load;
  logic        reg_we, pc_inc, pc_load, halted, mem_err;
  logic [2:0]  state;

  proc_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .psr(psr), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_load(ir_load), .src_latch(src_latch), .dst_latch(dst_latch),
    .alu_en(alu_en), .psr_load(psr_load), .reg_we(reg_we),
    .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted),
    .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  // Strobe bit positions in the packed pulse vector.
  localparam logic [7:0] P_IR  = 8'h80;
  localparam logic [7:0] P_SRC = 8'h40;
  localparam logic [7:0] P_DST = 8'h20;
  localparam logic [7:0] P_ALU = 8'h10;
  localparam logic [7:0] P_PSR = 8'h08;
  localparam logic [7:0] P_RWE = 8'h04;
  localparam logic [7:0] P_INC = 8'h02;
  localparam logic [7:0] P_PCL = 8'h01;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic [1:0] sel;
    logic [7:0] pul;
    logic       hlt;
    logic       err;
  } obs_t;

  typedef struct {
    logic ack;
    logic ir_valid;
    obs_t o;
  } cyc_t;

  cyc_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cur_instr = 32'h0;
  string       cur_tag = "init";

  function automatic obs_t mk(logic [2:0] st, logic req, logic we, logic [1:0] sel,
                              logic [7:0] pul, logic hlt, logic err);
    obs_t o;
    o.st = st; o.req = req; o.we = we; o.sel = sel;
    o.pul = pul; o.hlt = hlt; o.err = err;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.st  = state;
    o.req = mem_req;
    o.we  = mem_we;
    o.sel = mem_sel;
    o.pul = {ir_load, src_latch, dst_latch, alu_en, psr_load, reg_we, pc_inc, pc_load};
    o.hlt = halted;
    o.err = mem_err;
    return o;
  endfunction

  // Branch truth table written from the condition-code list.
  function automatic logic branch_taken(logic [3:0] cc, logic [4:0] p);
    logic carry, parity, even, neg, zero;
    {zero, neg, even, parity, carry} = p;
    case (cc)
      4'd0: return 1'b1;
      4'd1: return parity;
      4'd2: return even;
      4'd3: return carry;
      4'd4: return neg;
      4'd5: return zero;
      4'd6: return !carry;
      4'd7: return !neg && !zero;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(string tag, obs_t expv);
    obs_t got;
    got = observe();
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, got, expv);
    end
  endtask

  // One-cycle phase with no memory request; ack is randomized to show it is ignored.
  task automatic push_single(logic [2:0] st, logic [7:0] pul, logic hlt, logic err);
    cyc_t c;
    c.ack = 1'($urandom_range(0, 1));
    c.ir_valid = 1'b1;
    c.o = mk(st, 1'b0, 1'b0, 2'd0, pul, hlt, err);
    exp_q.push_back(c);
  endtask

  // Memory phase: 'delay' unacknowledged cycles, then the ack cycle with its strobe.
  task automatic push_access(logic [2:0] st, logic [1:0] sel, logic we, int delay,
                             logic [7:0] pul, logic ir_valid);
    cyc_t c;
    for (int i = 0; i < delay; i++) begin
      c.ack = 1'b0; c.ir_valid = ir_valid;
      c.o = mk(st, 1'b1, we, sel, 8'h00, 1'b0, 1'b0);
      exp_q.push_back(c);
    end
    c.ack = 1'b1; c.ir_valid = ir_valid;
    c.o = mk(st, 1'b1, we, sel, pul, 1'b0, 1'b0);
    exp_q.push_back(c);
  endtask

  task automatic build_instr(logic [31:0] ins, logic [4:0] p, int d0, int d1, int d2, int d3);
    logic [3:0] op;
    logic       imm;
    op = ins[31:28];
    imm = ins[27];
    cur_instr = ins;
    psr = p;
    push_access(3'd0, 2'd0, 1'b0, d0, P_IR, 1'b0);
    case (op)
      4'd1: begin
        push_single(3'd1, 8'h00, 1'b0, 1'b0);
        if (!imm) push_access(3'd2, 2'd1, 1'b0, d1, P_SRC, 1'b1);
        push_single(3'd5, P_RWE | P_INC, 1'b0, 1'b0);
      end
      4'd2: begin
        push_single(3'd1, 8'h00, 1'b0, 1'b0);
        push_access(3'd5, 2'd2, 1'b1, d3, P_INC, 1'b1);
      end
      4'd3: push_single(3'd1, branch_taken(ins[27:24], p) ? P_PCL : P_INC, 1'b0, 1'b0);
      4'd4, 4'd5, 4'd6, 4'd7, 4'd9: begin
        push_single(3'd1, 8'h00, 1'b0, 1'b0);
        if (!imm) push_access(3'd2, 2'd1, 1'b0, d1, P_SRC, 1'b1);
        push_access(3'd3, 2'd2, 1'b0, d2, P_DST, 1'b1);
        push_single(3'd4, P_ALU | P_PSR, 1'b0, 1'b0);
        push_access(3'd5, 2'd2, 1'b1, d3, P_INC, 1'b1);
      end
      4'd8: begin
        push_single(3'd1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) push_single(3'd6, 8'h00, 1'b1, 1'b0);
      end
      default: push_single(3'd1, P_INC, 1'b0, 1'b0);
    endcase
  endtask

  task automatic run_one();
    cyc_t c;
    c = exp_q.pop_front();
    @(negedge clk);
    mem_ack = c.ack;
    instr = c.ir_valid ? cur_instr : $urandom;
    #1;
    check(cur_tag, c.o);
  endtask

  task automatic run_q();
    while (exp_q.size() > 0) run_one();
  endtask

  task automatic exec(string tag, logic [31:0] ins, logic [4:0] p,
                      int d0, int d1, int d2, int d3);
    cur_tag = tag;
    build_instr(ins, p, d0, d1, d2, d3);
    run_q();
  endtask

  // Assert reset mid-cycle, confirm all outputs drop at once, release after an edge.
  task automatic pulse_reset(string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    mem_ack = 1'b1;
    #1 check(tag, mk(3'd0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] ins;
    cyc_t        c;

    // Reset state: everything low, state reads FETCH.
    #1 rst = 1'b1;
    mem_ack = 1'b1;
    #1 check("reset_async", mk(3'd0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
    @(posedge clk);
    #1 check("reset_held", mk(3'd0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
    #1 rst = 1'b0;
    mem_ack = 1'b0;

    // Directed cases.
    exec("add_zero_wait", 32'h5000_1002, 5'h00, 0, 0, 0, 0);
    exec("bra_zero_taken", 32'h3500_0010, 5'b10000, 0, 0, 0, 0);
    exec("bra_zero_not", 32'h3500_0010, 5'b00000, 0, 0, 0, 0);
    exec("bra_never", 32'h3800_0010, 5'b11111, 0, 0, 0, 0);
    exec("bra_positive", 32'h3700_0010, 5'b00001, 0, 0, 0, 0);
    exec("fetch_wait3", 32'h0000_0000, 5'h00, 3, 0, 0, 0);
    exec("ld_imm", 32'h1800_1002, 5'h00, 0, 0, 0, 0);
    exec("ld_mem", 32'h1000_1002, 5'h00, 1, 2, 0, 0);
    exec("str", 32'h2000_1002, 5'h00, 0, 0, 0, 2);
    exec("cmp_imm", 32'h9800_1002, 5'h00, 0, 0, 1, 3);

    // Randomized instruction stream (HLT excluded), ack delays 0..3.
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd8) op = 4'd5;
      ins = {op, 28'($urandom)};
      exec("rand", ins, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // HLT stays halted with no requests, then reset restarts fetching.
    exec("halt", 32'h8000_0000, 5'h00, 0, 0, 0, 0);
    pulse_reset("halt_reset");
    exec("after_halt", 32'h0000_0000, 5'h00, 2, 0, 0, 0);

    // Reset while waiting in RD_DST: request drops, no dst_latch.
    cur_tag = "rst_rd_dst";
    build_instr(32'h5000_1002, 5'h00, 0, 0, 3, 0);
    for (int i = 0; i < 4; i++) run_one();
    #1 rst = 1'b1;
    mem_ack = 1'b1;
    #1 check("rst_rd_dst_drop", mk(3'd0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    mem_ack = 1'b0;
    exec("after_rst", 32'h5800_1002, 5'h00, 0, 0, 0, 0);

    // Ack timeout: four unacknowledged fetch cycles, then HALT with mem_err.
    cur_tag = "timeout";
    for (int i = 0; i < 4; i++) begin
      c.ack = 1'b0; c.ir_valid = 1'b0;
      c.o = mk(3'd0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
      exp_q.push_back(c);
    end
    for (int i = 0; i < 6; i++) push_single(3'd6, 8'h00, 1'b1, 1'b1);
    run_q();
    pulse_reset("err_reset");
    exec("after_err", 32'h2000_0003, 5'h00, 1, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Multicycle control unit that sequences the HW3 processor datapath through fetch, decode, operand read, execute and writeback.
- Owns the single shared memory port through a req/ack handshake.
- Decodes the instruction held in the datapath IR and drives the datapath strobes: IR load, operand latches, ALU enable, PSR load, PC update, register write.
- Evaluates branch conditions against the PSR.

Parameters:
- WAIT_LIMIT, 0, max cycles to wait for mem_ack before asserting mem_err (0 = unlimited).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  32  current IR contents. Fields: opcode [31:28], cc [27:24], src_type [27] (1 = immediate), src_addr [23:12], dest_addr [11:0].
- psr  in  5  status: [0] carry, [1] parity, [2] even, [3] negative, [4] zero.
- mem_ack  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- mem_sel  out  2  address source: 0 = PC, 1 = src_addr, 2 = dest_addr.
- ir_load  out  1  IR captures read data.
- src_latch  out  1  source operand register captures read data.
- dst_latch  out  1  destination operand register captures read data.
- alu_en  out  1  ALU result register captures; opcode is taken from instr.
- psr_load  out  1  PSR updates from ALU flags.
- reg_we  out  1  register file write (LD).
- pc_inc  out  1  PC <= PC + 1.
- pc_load  out  1  PC <= dest_addr (branch taken).
- halted  out  1  processor in HALT.
- mem_err  out  1  sticky: ack timeout occurred.
- state  out  3  current state, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, RD_SRC=2, RD_DST=3, EXEC=4, WB=5, HALT=6.
- Reset (async): state=FETCH. All strobes, mem_req, mem_we, halted and mem_err are 0 while rst is high. FETCH outputs start the first cycle after release.
- Pulse outputs (ir_load, src_latch, dst_latch, alu_en, psr_load, reg_we, pc_inc, pc_load) are combinational from state and inputs, high for exactly one cycle. pc_inc and pc_load are never both high.
- Handshake:
  - mem_req is held high with mem_sel and mem_we stable until the first cycle with mem_ack=1. The transfer completes in that cycle.
  - mem_ack while mem_req=0 is ignored.
  - Zero-wait memory (ack tied high) completes each access in one cycle.
- FETCH: mem_req=1, sel=0, we=0. On ack: ir_load=1, go to DECODE.
- DECODE (1 cycle), action by opcode:
  - 0 NOP, and undefined 10..15: pc_inc, go to FETCH.
  - 8 HLT: go to HALT.
  - 3 BRA: if the condition is true then pc_load, else pc_inc; go to FETCH.
  - 1 LD: if src_type=1 (immediate) go to WB, else go to RD_SRC.
  - 2 STR: go to WB.
  - 4 XOR, 5 ADD, 6 ROT, 7 SHF, 9 CMP: RD_SRC if src_type=0; RD_DST if src_type=1.
- Branch conditions (cc):
  - 0 always; 1 parity; 2 even; 3 carry; 4 negative; 5 zero.
  - 6 no carry; 7 positive (!negative & !zero); 8..15 never.
- RD_SRC: req with sel=1. On ack: src_latch. LD then goes to WB; ALU ops go to RD_DST.
- RD_DST: req with sel=2. On ack: dst_latch, go to EXEC.
- EXEC (1 cycle): alu_en=1, psr_load=1. ROT, SHF and CMP also assert psr_load. Go to WB.
- WB:
  - LD: reg_we=1 and pc_inc in one cycle, no memory access; go to FETCH.
  - STR and ALU ops: req with we=1, sel=2. On ack: pc_inc, go to FETCH.
- HALT: terminal. halted=1, no strobes, no mem_req. Exit only by rst.
- Latency with zero-wait memory:
  - NOP, BRA: 2 cycles.
  - LD immediate: 3 cycles; LD memory: 4 cycles.
  - STR: 3 cycles.
  - ALU op, memory source: 6 cycles; ALU op, immediate source: 5 cycles.
- Ack timeout (WAIT_LIMIT>0): the wait counter clears on each new request. When the count reaches WAIT_LIMIT with no ack, mem_err is set, mem_req drops and state goes to HALT. mem_err clears only on rst.
- Reset mid-access: mem_req drops asynchronously. No partial strobes are emitted. PC reinitialisation is the datapath's responsibility.
- instr is sampled only in DECODE and in later states. The IR must stay stable from ir_load until the next FETCH.

Test Plan:
- Zero-wait, instr=0x5000_1002 (ADD mem[1]->mem[2]): state sequence 0,1,2,3,4,5,0 over 6 cycles. src_latch and dst_latch each pulse once; alu_en and psr_load in cycle 5; mem_we=1 only in WB; one pc_inc.
- BRA cc=5 with psr=5'b10000: pc_load=1, pc_inc=0. Same instruction with psr=0: pc_inc=1, pc_load=0. cc=8: never taken.
- Ack delayed 3 cycles during FETCH: mem_req high for 4 cycles with sel=0 stable; ir_load pulses only in the ack cycle.
- HLT (0x8000_0000): halted=1 from the cycle after DECODE, with no mem_req for 20 cycles. Pulsing rst returns state=0 and mem_req=1 the next cycle.
- rst asserted during RD_DST wait: mem_req falls without waiting for a clock edge; no dst_latch pulse. After release the controller fetches again.
- WAIT_LIMIT=4 with ack held low: mem_err=1 and state=6 after 4 wait cycles; mem_req=0 from then on.
